// File: rtl/result_acc_pkg.sv
// result_acc_pkg: shared state enum, default widths and sign-extend helper
package result_acc_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;
  localparam int ACC_BW_DEF = 32;
  localparam int TILE_BW_DEF = 8;
  function automatic logic [63:0] sext(input logic [63:0] x, input int bw);
    return 64'($signed(x << (64 - bw)) >>> (64 - bw));
  endfunction
endpackage

// File: rtl/acc_lane_add.sv
// acc_lane_add: lane-wise sign-extend-and-add, bypass passes sext(in_data); ports: bypass, acc, in_data -> sum
module acc_lane_add import result_acc_pkg::*; #(
  parameter int MATRIX_SIZE = 32,
  parameter int PARTIAL_SUM_BW = 24,
  parameter int ACC_BW = ACC_BW_DEF
) (
  input  logic                            bypass,
  input  logic [ACC_BW*MATRIX_SIZE-1:0]   acc,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data,
  output logic [ACC_BW*MATRIX_SIZE-1:0]   sum
);
  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
    logic [ACC_BW-1:0] ext;
    assign ext = ACC_BW'(sext(64'(in_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]), PARTIAL_SUM_BW));
    assign sum[i*ACC_BW +: ACC_BW] = bypass ? ext : acc[i*ACC_BW +: ACC_BW] + ext;
  end
endmodule

// File: rtl/result_accumulator.sv
// result_accumulator: accumulates 32-row result tiles over K-tiles, then drains rows on a valid/ready stream.
// Ports: clk, rst, start/num_tiles (job), in_valid/in_row/in_data (rows), out_* (drain), busy, done, err.
// RESULT_ACC_RELU_EN: when defined, drained lanes are clamped to max(lane, 0).
module result_accumulator import result_acc_pkg::*; #(
  parameter int MATRIX_SIZE = 32,
  parameter int PARTIAL_SUM_BW = 24,
  parameter int ACC_BW = ACC_BW_DEF,
  parameter int TILE_BW = TILE_BW_DEF,
  parameter int ROW_BW = $clog2(MATRIX_SIZE)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [TILE_BW-1:0]                    num_tiles,
  input  logic                                  in_valid,
  input  logic [ROW_BW-1:0]                     in_row,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ROW_BW-1:0]                     out_row,
  output logic [ACC_BW*MATRIX_SIZE-1:0]         out_data,
  output logic                                  out_last,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err
);
  localparam int W = ACC_BW * MATRIX_SIZE;
  state_e state_q, state_d;
  logic [TILE_BW-1:0] tiles_q, tiles_d, tile_cnt_q, tile_cnt_d;
  logic [ROW_BW-1:0] rd_ptr_q, rd_ptr_d;
  logic err_q, err_d, done_q, done_d;
  logic [W-1:0] buf_q [MATRIX_SIZE];
  logic [W-1:0] sum, rd;
  logic wr_en, row_last, tile_last, drain_last;
  assign wr_en = state_q == ACCUM && in_valid;
  assign row_last = in_row == ROW_BW'(MATRIX_SIZE - 1);
  assign tile_last = tile_cnt_q == tiles_q - TILE_BW'(1);
  assign drain_last = rd_ptr_q == ROW_BW'(MATRIX_SIZE - 1);
  acc_lane_add #(.MATRIX_SIZE(MATRIX_SIZE), .PARTIAL_SUM_BW(PARTIAL_SUM_BW), .ACC_BW(ACC_BW)) u_add (
    .bypass (tile_cnt_q == '0),
    .acc    (buf_q[in_row]),
    .in_data(in_data),
    .sum    (sum)
  );
  always_comb begin
    state_d = state_q;
    tiles_d = tiles_q;
    tile_cnt_d = tile_cnt_q;
    rd_ptr_d = rd_ptr_q;
    err_d = err_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          tiles_d = num_tiles == '0 ? TILE_BW'(1) : num_tiles;
          tile_cnt_d = '0;
          err_d = 1'b0;
        end else if (in_valid) begin
          err_d = 1'b1;
        end
      end
      ACCUM: begin
        if (in_valid && row_last) begin
          tile_cnt_d = tile_cnt_q + TILE_BW'(1);
          if (tile_last) begin
            state_d = DRAIN;
            rd_ptr_d = '0;
          end
        end
      end
      DRAIN: begin
        if (in_valid) err_d = 1'b1;
        if (out_ready) begin
          rd_ptr_d = rd_ptr_q + ROW_BW'(1);
          if (drain_last) begin
            state_d = IDLE;
            done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tiles_q <= '0;
      tile_cnt_q <= '0;
      rd_ptr_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tiles_q <= tiles_d;
      tile_cnt_q <= tile_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      err_q <= err_d;
      done_q <= done_d;
    end
  end
  // Buffer has no reset: the first tile of every job overwrites each row.
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[in_row] <= sum;
  end
  assign out_valid = state_q == DRAIN;
  assign out_row = rd_ptr_q;
  assign out_last = out_valid && drain_last;
  assign rd = out_valid ? buf_q[rd_ptr_q] : '0;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err = err_q;
`ifdef RESULT_ACC_RELU_EN
  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_relu
    assign out_data[i*ACC_BW +: ACC_BW] = rd[(i+1)*ACC_BW-1] ? '0 : rd[i*ACC_BW +: ACC_BW];
  end
`else
  assign out_data = rd;
`endif
endmodule

// File: tb/tb_result_accumulator.sv
// tb_result_accumulator: directed self-checking bench for result_accumulator (32-bit and 24-bit accumulator instances)
module tb_result_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] num_tiles = '0;
  logic in_valid = 1'b0;
  logic [4:0] in_row = '0;
  logic [767:0] in_data = '0;
  logic out_ready = 1'b0;
  logic out_valid, out_last, busy, done, err;
  logic [4:0] out_row;
  logic [1023:0] out_data;
  logic o24_valid, o24_last, busy24, done24, err24;
  logic [4:0] o24_row;
  logic [767:0] o24_data;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  result_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .in_valid(in_valid),
    .in_row(in_row), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_data(out_data), .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  result_accumulator #(.ACC_BW(24)) dut24 (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .in_valid(in_valid),
    .in_row(in_row), .in_data(in_data), .out_valid(o24_valid), .out_ready(out_ready),
    .out_row(o24_row), .out_data(o24_data), .out_last(o24_last), .busy(busy24), .done(done24), .err(err24)
  );

  function automatic logic [31:0] rl32(input logic [31:0] x);
`ifdef RESULT_ACC_RELU_EN
    return x[31] ? 32'd0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [23:0] rl24(input logic [23:0] x);
`ifdef RESULT_ACC_RELU_EN
    return x[23] ? 24'd0 : x;
`else
    return x;
`endif
  endfunction

  task automatic begin_job(input logic [7:0] n);
    @(negedge clk);
    start = 1'b1;
    num_tiles = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives rows 0..nrows-1; returns on the negedge after the last row was captured.
  task automatic send_tile(input logic [23:0] v, input int nrows, input bit by_row);
    for (int r = 0; r < nrows; r++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_row = 5'(r);
      in_data = by_row ? {32{24'(r)}} : {32{v}};
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_row, out_last, busy, done, err} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0", {out_valid, out_row, out_last, busy, done, err});
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", out_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_tile();
    out_ready = 1'b1;
    begin_job(8'd1);
    send_tile(24'd0, 32, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_valid_latency: got %b expected 1", out_valid);
    end
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (out_row !== 5'(r) || out_data !== {32{32'(r)}} || out_last !== (r == 31)) begin
        errors++;
        $display("FAIL single_row%0d: got row %0d last %b lane0 %h expected row %0d lane %h", r, out_row, out_last, out_data[31:0], r, 32'(r));
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got done %b busy %b expected 1 0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_multi_tile();
    logic [31:0] e32;
    logic [23:0] e24;
    e32 = rl32(32'hFFFFFFF1);
    e24 = rl24(24'hFFFFF1);
    begin_job(8'd3);
    repeat (3) send_tile(-24'sd5, 32, 1'b0);
    checks++;
    if (dut.tile_cnt_q !== 8'd3 || err !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL multi_state: got tile_cnt %0d err %b valid %b expected 3 0 1", dut.tile_cnt_q, err, out_valid);
    end
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (out_data !== {32{e32}} || o24_data !== {32{e24}}) begin
        errors++;
        $display("FAIL multi_row%0d: got %h / %h expected %h / %h", r, out_data[31:0], o24_data[23:0], e32, e24);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int r, hs, cyc;
    pat = 4'b1001;
    r = 0;
    hs = 0;
    cyc = 0;
    out_ready = 1'b0;
    begin_job(8'd1);
    send_tile(24'd0, 32, 1'b1);
    while (r < 32 && cyc < 200) begin
      checks++;
      if (out_valid !== 1'b1 || out_row !== 5'(r) || out_data !== {32{32'(r)}} || out_last !== (r == 31)) begin
        errors++;
        $display("FAIL bp_cycle%0d: got valid %b row %0d last %b lane0 %h expected row %0d", cyc, out_valid, out_row, out_last, out_data[31:0], r);
      end
      out_ready = pat[cyc % 4];
      @(negedge clk);
      if (out_ready) begin
        r++;
        hs++;
      end
      cyc++;
    end
    out_ready = 1'b1;
    checks++;
    if (hs !== 32 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: got handshakes %0d done %b busy %b expected 32 1 0", hs, done, busy);
    end
  endtask

  task automatic test_wrap();
    logic [23:0] e24;
    e24 = rl24(24'hFFFFFE);
    begin_job(8'd2);
    repeat (2) send_tile(24'h7FFFFF, 32, 1'b0);
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (out_data !== {32{32'h00FFFFFE}} || o24_data !== {32{e24}}) begin
        errors++;
        $display("FAIL wrap_row%0d: got %h / %h expected 00fffffe / %h", r, out_data[31:0], o24_data[23:0], e24);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_protocol();
    @(negedge clk);
    in_valid = 1'b1;
    in_row = 5'd0;
    in_data = {32{24'h123456}};
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || dut.buf_q[0] !== {32{32'h00FFFFFE}}) begin
      errors++;
      $display("FAIL proto_idle_row: got err %b busy %b row0 %h expected 1 0 00fffffe", err, busy, dut.buf_q[0][31:0]);
    end
    @(negedge clk);
    start = 1'b1;
    num_tiles = 8'd0;
    in_valid = 1'b1;
    in_row = 5'd5;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || err !== 1'b0 || dut.buf_q[5] !== {32{32'h00FFFFFE}}) begin
      errors++;
      $display("FAIL proto_start_row: got busy %b err %b row5 %h expected 1 0 00fffffe", busy, err, dut.buf_q[5][31:0]);
    end
    send_tile(24'd3, 32, 1'b0);
    start = 1'b1;
    num_tiles = 8'd4;
    in_valid = 1'b1;
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (out_row !== 5'(r) || out_data !== {32{32'd3}}) begin
        errors++;
        $display("FAIL proto_drain_row%0d: got row %0d lane0 %h expected %0d 00000003", r, out_row, out_data[31:0], r);
      end
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b0;
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("FAIL proto_drain_end: got busy %b done %b err %b expected 0 1 1", busy, done, err);
    end
    begin_job(8'd1);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL proto_err_clear: got err %b busy %b expected 0 1", err, busy);
    end
    send_tile(24'd1, 32, 1'b0);
    repeat (33) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    begin_job(8'd2);
    send_tile(24'd9, 10, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({out_valid, out_row, out_last, busy, done, err} !== 10'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL mid_reset: got %b expected 0", {out_valid, out_row, out_last, busy, done, err});
    end
    begin_job(8'd1);
    send_tile(24'd7, 32, 1'b0);
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== {32{32'd7}}) begin
        errors++;
        $display("FAIL mid_row%0d: got valid %b lane0 %h expected 1 00000007", r, out_valid, out_data[31:0]);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL mid_done: got %b expected 1", done);
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_backpressure();
    test_wrap();
    test_protocol();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
